// File: rtl/pc_sequencer.sv
// Fetch program counter with prioritised next-PC selection, circular return-address
// stack, exception PC capture and a one-cycle redirect flag for pipeline flushing.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
  parameter int unsigned      STEP         = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               PC_Write,
  input  logic                               Branch_Taken,
  input  logic [WIDTH-1:0]                   Branch_Target,
  input  logic                               Jump,
  input  logic                               Call,
  input  logic [WIDTH-1:0]                   Jump_Target,
  input  logic                               Return,
  input  logic [WIDTH-1:0]                   Return_Target,
  input  logic                               Exception,
  output logic [WIDTH-1:0]                   PCResult,
  output logic [WIDTH-1:0]                   PCPlus,
  output logic [WIDTH-1:0]                   EPC,
  output logic                               Redirect,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     RAS_Count,
  output logic                               RAS_Empty,
  output logic                               RAS_Full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_redirect;
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];

  logic [WIDTH-1:0] w_pc_plus;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_epc_next;
  logic             w_redirect_next;
  logic [PTR_W-1:0] w_ptr_next;
  logic [PTR_W-1:0] w_ptr_dec;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_push;
  logic             w_empty;
  logic             w_full;

  assign w_pc_plus = r_pc + WIDTH'(STEP);
  assign w_ptr_dec = r_ptr - PTR_W'(1);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_W'(RAS_DEPTH));

  // Next-state selection in priority order: exception, stall, branch, return, call, jump, step.
  always_comb begin
    w_pc_next       = r_pc;
    w_epc_next      = r_epc;
    w_redirect_next = 1'b0;
    w_ptr_next      = r_ptr;
    w_cnt_next      = r_cnt;
    w_push          = 1'b0;
    if (Exception) begin
      w_pc_next       = EXC_VECTOR;
      w_epc_next      = r_pc;
      w_redirect_next = 1'b1;
    end else if (PC_Write) begin
      if (Branch_Taken) begin
        w_pc_next       = Branch_Target;
        w_redirect_next = 1'b1;
      end else if (Return) begin
        w_redirect_next = 1'b1;
        if (w_empty) begin
          w_pc_next = Return_Target;
        end else begin
          w_pc_next  = r_ras[w_ptr_dec];
          w_ptr_next = w_ptr_dec;
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end else if (Call) begin
        // Pointer names the next free slot, which is also the oldest entry when full.
        w_pc_next       = Jump_Target;
        w_push          = 1'b1;
        w_ptr_next      = r_ptr + PTR_W'(1);
        w_cnt_next      = w_full ? r_cnt : r_cnt + CNT_W'(1);
        w_redirect_next = 1'b1;
      end else if (Jump) begin
        w_pc_next       = Jump_Target;
        w_redirect_next = 1'b1;
      end else begin
        w_pc_next = w_pc_plus;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc       <= RESET_VECTOR;
      r_epc      <= '0;
      r_redirect <= 1'b0;
      r_ptr      <= '0;
      r_cnt      <= '0;
    end else begin
      r_pc       <= w_pc_next;
      r_epc      <= w_epc_next;
      r_redirect <= w_redirect_next;
      r_ptr      <= w_ptr_next;
      r_cnt      <= w_cnt_next;
    end
  end

  // Stack contents carry no reset value; only pointer and count define validity.
  always_ff @(posedge Clk) begin
    if (w_push && !Reset) begin
      r_ras[r_ptr] <= w_pc_plus;
    end
  end

  assign PCResult  = r_pc;
  assign PCPlus    = w_pc_plus;
  assign EPC       = r_epc;
  assign Redirect  = r_redirect;
  assign RAS_Count = r_cnt;
  assign RAS_Empty = w_empty;
  assign RAS_Full  = w_full;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        PC_Write, Branch_Taken, Jump, Call, Return, Exception;
  logic [31:0] Branch_Target, Jump_Target, Return_Target;
  logic [31:0] PCResult, PCPlus, EPC;
  logic        Redirect, RAS_Empty, RAS_Full;
  logic [2:0]  RAS_Count;

  logic       n_pc_write, n_branch;
  logic [7:0] n_branch_target;
  logic [7:0] n_pc, n_pc_plus, n_epc;
  logic       n_redirect, n_empty, n_full;
  logic [2:0] n_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] m_pc, m_epc;
  logic        m_red;
  logic [31:0] m_ras [$];

  always #5 Clk = ~Clk;

  pc_sequencer u_dut (
    .Clk(Clk), .Reset(Reset), .PC_Write(PC_Write),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .Jump(Jump), .Call(Call), .Jump_Target(Jump_Target),
    .Return(Return), .Return_Target(Return_Target), .Exception(Exception),
    .PCResult(PCResult), .PCPlus(PCPlus), .EPC(EPC), .Redirect(Redirect),
    .RAS_Count(RAS_Count), .RAS_Empty(RAS_Empty), .RAS_Full(RAS_Full)
  );

  pc_sequencer #(.WIDTH(8), .STEP(4), .RAS_DEPTH(4)) u_dut8 (
    .Clk(Clk), .Reset(Reset), .PC_Write(n_pc_write),
    .Branch_Taken(n_branch), .Branch_Target(n_branch_target),
    .Jump(1'b0), .Call(1'b0), .Jump_Target(8'h00),
    .Return(1'b0), .Return_Target(8'h00), .Exception(1'b0),
    .PCResult(n_pc), .PCPlus(n_pc_plus), .EPC(n_epc), .Redirect(n_redirect),
    .RAS_Count(n_count), .RAS_Empty(n_empty), .RAS_Full(n_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_epc = 32'h0;
    m_red = 1'b0;
    m_ras.delete();
  endtask

  task automatic check_all();
    chk("pc",       PCResult,  m_pc);
    chk("pcplus",   PCPlus,    m_pc + 32'd4);
    chk("epc",      EPC,       m_epc);
    chk("redirect", 32'(Redirect),  32'(m_red));
    chk("count",    32'(RAS_Count), 32'(m_ras.size()));
    chk("empty",    32'(RAS_Empty), 32'(m_ras.size() == 0));
    chk("full",     32'(RAS_Full),  32'(m_ras.size() == 4));
  endtask

  // Drive one cycle's request, advance the model, then check just after the edge.
  task automatic cycle(input logic pw, input logic exc, input logic bt, input logic ret,
                       input logic call, input logic jmp, input logic [31:0] bt_t,
                       input logic [31:0] jt, input logic [31:0] rt);
    PC_Write = pw; Exception = exc; Branch_Taken = bt; Return = ret;
    Call = call; Jump = jmp; Branch_Target = bt_t; Jump_Target = jt; Return_Target = rt;
    if (exc) begin
      m_epc = m_pc; m_pc = 32'h180; m_red = 1'b1;
    end else if (!pw) begin
      m_red = 1'b0;
    end else if (bt) begin
      m_pc = bt_t; m_red = 1'b1;
    end else if (ret) begin
      m_red = 1'b1;
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else m_pc = rt;
    end else if (call) begin
      if (m_ras.size() == 4) void'(m_ras.pop_front());
      m_ras.push_back(m_pc + 32'd4);
      m_pc = jt; m_red = 1'b1;
    end else if (jmp) begin
      m_pc = jt; m_red = 1'b1;
    end else begin
      m_pc = m_pc + 32'd4; m_red = 1'b0;
    end
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_call(input logic [31:0] t);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, t, 32'h0);
  endtask

  task automatic do_ret(input logic [31:0] rt);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, rt);
  endtask

  task automatic do_jump(input logic [31:0] t);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, t, 32'h0);
  endtask

  initial begin
    Reset = 1'b1;
    PC_Write = 1'b0; Exception = 1'b0; Branch_Taken = 1'b0; Return = 1'b0;
    Call = 1'b0; Jump = 1'b0; Branch_Target = '0; Jump_Target = '0; Return_Target = '0;
    n_pc_write = 1'b0; n_branch = 1'b0; n_branch_target = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_pc", PCResult, 32'h0);
    chk("rst_epc", EPC, 32'h0);
    chk("rst_redirect", 32'(Redirect), 32'h0);
    chk("rst_empty", 32'(RAS_Empty), 32'h1);
    Reset = 1'b0;

    // Sequential fetch from the reset vector.
    idle(); chk("seq1", PCResult, 32'h4);
    idle(); chk("seq2", PCResult, 32'h8);
    idle(); chk("seq3", PCResult, 32'hC);

    // Stalled branch is ignored, then taken once writes resume.
    idle(); chk("pc10", PCResult, 32'h10);
    repeat (2) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0);
      chk("stall_pc", PCResult, 32'h10);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0);
    chk("br_pc", PCResult, 32'h100);
    chk("br_redirect", 32'(Redirect), 32'h1);
    idle(); chk("br_redirect_drop", 32'(Redirect), 32'h0);

    // Nested call / return.
    do_jump(32'h20);
    do_call(32'h400); chk("call1", PCResult, 32'h400); chk("cnt1", 32'(RAS_Count), 32'd1);
    do_call(32'h800); chk("call2", PCResult, 32'h800); chk("cnt2", 32'(RAS_Count), 32'd2);
    do_ret(32'h0);    chk("ret1", PCResult, 32'h404);  chk("cnt3", 32'(RAS_Count), 32'd1);
    do_ret(32'h0);    chk("ret2", PCResult, 32'h24);   chk("cnt4", 32'(RAS_Count), 32'd0);

    // Overflow overwrites the oldest entry; empty return falls back.
    do_jump(32'h0);
    for (int i = 1; i <= 5; i++) do_call(32'(i) * 32'h100);
    chk("ovf_full", 32'(RAS_Full), 32'h1);
    chk("ovf_cnt", 32'(RAS_Count), 32'd4);
    for (int i = 4; i >= 1; i--) begin
      do_ret(32'h0);
      chk("ovf_ret", PCResult, 32'(i) * 32'h100 + 32'h4);
    end
    do_ret(32'hABC);
    chk("empty_ret", PCResult, 32'hABC);
    chk("empty_cnt", 32'(RAS_Count), 32'd0);

    // Exception beats stall and branch; Call+Return does only the pop.
    do_jump(32'h50);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0);
    chk("exc_pc", PCResult, 32'h180);
    chk("exc_epc", EPC, 32'h50);
    chk("exc_redirect", 32'(Redirect), 32'h1);
    do_call(32'h600);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h700, 32'h0);
    chk("callret_pc", PCResult, 32'h184);
    chk("callret_cnt", 32'(RAS_Count), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 8) != 0, ($urandom % 20) == 0, ($urandom % 6) == 0,
            ($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 5) == 0,
            $urandom, $urandom, $urandom);
    end

    // Address wrap in the top address and in an 8-bit instance.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0);
    chk("wrap32_plus", PCPlus, 32'h0);
    idle(); chk("wrap32_pc", PCResult, 32'h0);
    n_pc_write = 1'b1; n_branch = 1'b1; n_branch_target = 8'hFC;
    @(posedge Clk); #1;
    chk("w8_pc", 32'(n_pc), 32'hFC);
    chk("w8_plus", 32'(n_pc_plus), 32'h00);
    n_branch = 1'b0;
    @(posedge Clk); #1;
    chk("w8_wrap", 32'(n_pc), 32'h00);

    // Asynchronous reset mid-cycle takes effect before the next edge.
    do_call(32'h900);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    chk("arst_pc", PCResult, 32'h0);
    chk("arst_epc", EPC, 32'h0);
    chk("arst_redirect", 32'(Redirect), 32'h0);
    chk("arst_cnt", 32'(RAS_Count), 32'd0);
    chk("arst_pc8", 32'(n_pc), 32'h0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    idle(); chk("post_rst", PCResult, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer that replaces the plain PC register in the instruction fetch unit. It holds the fetch address and computes the next PC from five sources, in priority order: exception vector, taken branch, return, jump/call, sequential increment. It contains a small circular return-address stack (RAS) for call/return, an exception PC capture register, and a registered redirect flag that the pipeline uses for flushing.

Parameters:
WIDTH, 32, address width in bits
RESET_VECTOR, 32'h00000000, PC value loaded on reset
EXC_VECTOR, 32'h00000180, PC value loaded on exception
STEP, 4, sequential increment in bytes
RAS_DEPTH, 4, return-stack entries; power of two, minimum 2

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
PC_Write  in  1  1 = PC may update; 0 = stall (hold)
Branch_Taken  in  1  redirect to Branch_Target
Branch_Target  in  WIDTH  branch destination
Jump  in  1  redirect to Jump_Target
Call  in  1  redirect to Jump_Target and push return address
Jump_Target  in  WIDTH  jump/call destination
Return  in  1  redirect to popped RAS entry
Return_Target  in  WIDTH  fallback return address (register value) used when RAS is empty
Exception  in  1  redirect to EXC_VECTOR and capture EPC
PCResult  out  WIDTH  current fetch address (registered)
PCPlus  out  WIDTH  PCResult + STEP (combinational)
EPC  out  WIDTH  PC captured at last exception (registered)
Redirect  out  1  registered; 1 for one cycle after any non-sequential update
RAS_Count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
RAS_Empty  out  1  RAS_Count == 0
RAS_Full  out  1  RAS_Count == RAS_DEPTH

Behaviour:
- Reset is asynchronous and active-high. While Reset is asserted: PCResult=RESET_VECTOR, EPC=0, Redirect=0, RAS_Count=0, RAS pointer=0. RAS entry contents are don't-care. Reset has priority over everything.
- All other state updates on the rising edge of Clk. Next-PC latency is one cycle.
- Arithmetic is modulo 2^WIDTH. PCPlus wraps, so all-ones minus STEP+1 wraps to a low address. There are no alignment checks.
- Per-edge priority, evaluated in order:
  1. Exception=1, applied regardless of PC_Write: PCResult<=EXC_VECTOR, EPC<=PCResult, Redirect<=1, RAS unchanged.
  2. Else if PC_Write=0: all state holds (PCResult, EPC, RAS), Redirect<=0. Branch, Jump, Call and Return are ignored.
  3. Else if Branch_Taken: PCResult<=Branch_Target, Redirect<=1.
  4. Else if Return:
     - RAS non-empty: PCResult<=top entry, pop (pointer-1, count-1).
     - RAS empty: PCResult<=Return_Target, count stays 0.
     - Redirect<=1 in both cases.
  5. Else if Call: PCResult<=Jump_Target, push PCPlus, Redirect<=1.
  6. Else if Jump: PCResult<=Jump_Target, Redirect<=1.
  7. Else: PCResult<=PCPlus, Redirect<=0.
- Simultaneous requests: a lower-priority request is dropped entirely, including its stack side effect. Call+Return in the same cycle performs only the Return. Call+Jump is treated as a Call.
- RAS is circular.
  - Push when full: overwrite the oldest entry, pointer advances, count saturates at RAS_DEPTH.
  - Pop when empty: no pointer or count change.
  - Pointer wraps modulo RAS_DEPTH in both directions.
- Reset mid-operation immediately forces the reset values. The first edge after Reset deasserts updates from RESET_VECTOR as in the priority rules.

Test Plan:
1. Reset then 3 edges, PC_Write=1, no requests -> PCResult 0x0, 0x4, 0x8, 0xC; Redirect=0 throughout; RAS_Empty=1.
2. PC=0x10, PC_Write=0 with Branch_Taken=1 to 0x100 for 2 cycles -> PCResult stays 0x10; then PC_Write=1 with Branch_Taken=1 -> PCResult=0x100; Redirect=1 for exactly one cycle.
3. PC=0x20: Call to 0x400; then at PC 0x400, Call to 0x800; then Return twice -> PCResult 0x400, 0x800, 0x404, 0x24; RAS_Count 1, 2, 1, 0.
4. RAS_DEPTH=4: five Calls from PCs 0x0, 0x100, 0x200, 0x300, 0x400 (return addresses 0x4–0x404) -> RAS_Full=1, count=4; four Returns yield 0x404, 0x304, 0x204, 0x104; fifth Return with RAS empty and Return_Target=0xABC -> PCResult=0xABC, count stays 0.
5. PC=0x50, PC_Write=0, Exception=1 with Branch_Taken=1 -> PCResult=0x180, EPC=0x50, Redirect=1; same-cycle Call+Return with a non-empty RAS -> only the pop occurs.
6. WIDTH=8, STEP=4, PC=0xFC -> next PCResult=0x00; assert Reset asynchronously mid-cycle -> PCResult=RESET_VECTOR before the next clock edge.
